// File: rtl/meter_packetizer_if.sv
// Sample input, UART byte handshake and status between the meter framing stage and its neighbours.
// Packetizer side uses the slave modport; whoever drives samples and models the UART uses the master modport.
interface meter_packetizer_if;
    logic        sample_valid;
    logic [11:0] data_v;
    logic [11:0] data_i;
    logic        tx_ready;
    logic [7:0]  tx_byte;
    logic        tx_en;
    logic        busy;
    logic        frame_done;
    logic [7:0]  overrun_cnt;

    modport master (
        output sample_valid, data_v, data_i, tx_ready,
        input  tx_byte, tx_en, busy, frame_done, overrun_cnt
    );

    modport slave (
        input  sample_valid, data_v, data_i, tx_ready,
        output tx_byte, tx_en, busy, frame_done, overrun_cnt
    );
endinterface

// File: rtl/meter_packetizer.sv
// Frames each V/I sample pair as 6 UART bytes: sync, {seq,V[11:8]}, V[7:0], I[11:8], I[7:0], checksum.
// Latency: sample_valid to first tx_en is 3 cycles when tx_ready is high.
// Backpressure: waits on tx_ready per byte; one pending sample slot, newer samples overwrite it and count an overrun.
module meter_packetizer #(
    parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    meter_packetizer_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SEND,
        S_WAIT_ACK,
        S_DONE
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [11:0] r_cap_v, r_cap_i;
    logic [11:0] r_pend_v, r_pend_i;
    logic        r_pend;
    logic [3:0]  r_seq;
    logic [2:0]  r_idx;
    logic [7:0]  r_csum;
    logic [7:0]  r_ovr;
    logic        r_tx_en, r_busy, r_frame_done;
    logic [7:0]  r_tx_byte;
    logic        w_strobe, w_last, w_in_idle;
    logic [7:0]  w_b1, w_byte;

    assign w_in_idle = (r_state == S_IDLE);
    assign w_b1      = {r_seq, r_cap_v[11:8]};

    always_comb begin
        w_state_nxt = r_state;
        w_strobe    = 1'b0;
        w_last      = 1'b0;
        unique case (r_state)
            S_IDLE:     if (bus.sample_valid || r_pend) w_state_nxt = S_LOAD;
            S_LOAD:     w_state_nxt = S_SEND;
            S_SEND: begin
                if (bus.tx_ready) begin
                    w_strobe    = 1'b1;
                    w_state_nxt = S_WAIT_ACK;
                end
            end
            S_WAIT_ACK: begin
                if (!bus.tx_ready) begin
                    w_last      = (r_idx == 3'd5);
                    w_state_nxt = w_last ? S_DONE : S_SEND;
                end
            end
            S_DONE:     w_state_nxt = S_IDLE;
            default:    w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_byte = SYNC_BYTE;
        case (r_idx)
            3'd1:    w_byte = w_b1;
            3'd2:    w_byte = r_cap_v[7:0];
            3'd3:    w_byte = {4'h0, r_cap_i[11:8]};
            3'd4:    w_byte = r_cap_i[7:0];
            3'd5:    w_byte = r_csum;
            default: w_byte = SYNC_BYTE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= S_IDLE;
        else          r_state <= w_state_nxt;
    end

    // Capture regs stay frozen for the whole frame; anything arriving meanwhile goes to the pending slot.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cap_v  <= '0;
            r_cap_i  <= '0;
            r_pend_v <= '0;
            r_pend_i <= '0;
            r_pend   <= 1'b0;
            r_ovr    <= '0;
            r_seq    <= '0;
            r_idx    <= '0;
            r_csum   <= '0;
        end else begin
            if (w_in_idle) begin
                r_pend <= 1'b0;
                if (bus.sample_valid) begin
                    r_cap_v <= bus.data_v;
                    r_cap_i <= bus.data_i;
                end else if (r_pend) begin
                    r_cap_v <= r_pend_v;
                    r_cap_i <= r_pend_i;
                end
            end else if (bus.sample_valid) begin
                r_pend   <= 1'b1;
                r_pend_v <= bus.data_v;
                r_pend_i <= bus.data_i;
            end
            if (bus.sample_valid && r_pend && (r_ovr != 8'hFF))
                r_ovr <= r_ovr + 8'd1;
            if (r_state == S_LOAD) begin
                r_idx  <= '0;
                r_csum <= w_b1 + r_cap_v[7:0] + {4'h0, r_cap_i[11:8]} + r_cap_i[7:0];
            end else if ((r_state == S_WAIT_ACK) && !bus.tx_ready && !w_last) begin
                r_idx <= r_idx + 3'd1;
            end
            if (r_state == S_DONE)
                r_seq <= r_seq + 4'd1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_tx_en      <= 1'b0;
            r_tx_byte    <= '0;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_tx_en      <= w_strobe;
            r_busy       <= (w_state_nxt != S_IDLE);
            r_frame_done <= w_last;
            if (w_strobe)
                r_tx_byte <= w_byte;
        end
    end

    assign bus.tx_en       = r_tx_en;
    assign bus.tx_byte     = r_tx_byte;
    assign bus.busy        = r_busy;
    assign bus.frame_done  = r_frame_done;
    assign bus.overrun_cnt = r_ovr;
endmodule

// File: tb/tb_meter_packetizer.sv
// Directed sequence with randomized payloads and UART response delays, scored against a frame-level model.
module tb_meter_packetizer;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc   = 0;

    logic [7:0] rx_q[$];
    int         rx_cyc[$];
    int         done_cnt = 0;
    int         done_cyc = 0;
    logic       prev_en  = 1'b0;
    logic       prev_done = 1'b0;
    bit         uart_auto = 1'b1;
    int         uart_min = 1;
    int         uart_max = 4;
    int         seq_m = 0;
    int         ovr_m = 0;

    meter_packetizer_if bus ();

    meter_packetizer dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Byte monitor plus handshake protocol checks.
    initial forever begin
        @(negedge clk);
        if (bus.tx_en === 1'b1) begin
            chk("en_while_ready", bus.tx_ready, 1);
            chk("en_single_cycle", prev_en, 0);
            rx_q.push_back(bus.tx_byte);
            rx_cyc.push_back(cyc);
        end
        if (bus.frame_done === 1'b1) begin
            chk("done_single_cycle", prev_done, 0);
            done_cnt++;
            done_cyc = cyc;
        end
        prev_en   = bus.tx_en;
        prev_done = bus.frame_done;
    end

    // UART: after accepting a byte, goes not-ready for a random number of cycles.
    initial begin
        bus.tx_ready = 1'b1;
        forever begin
            @(negedge clk);
            if (uart_auto && bus.tx_en === 1'b1) begin
                @(posedge clk);
                #1 bus.tx_ready = 1'b0;
                repeat ($urandom_range(uart_max, uart_min)) @(posedge clk);
                #1 bus.tx_ready = 1'b1;
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic send_sample(input logic [11:0] v, input logic [11:0] i);
        @(negedge clk);
        bus.sample_valid = 1'b1;
        bus.data_v       = v;
        bus.data_i       = i;
        @(posedge clk);
        #1 bus.sample_valid = 1'b0;
    endtask

    task automatic wait_bytes(input int n, input string tag);
        int c = 0;
        while (rx_q.size() < n && c < 2000) begin
            @(posedge clk);
            c++;
        end
        chk({tag, "_bytes_timeout"}, rx_q.size() >= n, 1);
    endtask

    task automatic reset_dut();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        rx_q.delete();
        rx_cyc.delete();
        seq_m = 0;
        ovr_m = 0;
    endtask

    task automatic expect_frame(input logic [11:0] v, input logic [11:0] i, input string tag,
                                output int first_cyc, output int dcyc);
        logic [7:0] e[6];
        int d0 = done_cnt;
        int c = 0;
        first_cyc = -1;
        dcyc      = -1;
        while (done_cnt == d0 && c < 4000) begin
            @(posedge clk);
            c++;
        end
        chk({tag, "_done_timeout"}, done_cnt != d0, 1);
        dcyc = done_cyc;
        e[0] = 8'hA5;
        e[1] = 8'((seq_m % 16) * 16 + int'(v) / 256);
        e[2] = 8'(int'(v) % 256);
        e[3] = 8'(int'(i) / 256);
        e[4] = 8'(int'(i) % 256);
        e[5] = 8'((int'(e[1]) + int'(e[2]) + int'(e[3]) + int'(e[4])) % 256);
        seq_m = (seq_m + 1) % 16;
        chk({tag, "_len"}, rx_q.size() >= 6, 1);
        if (rx_q.size() >= 6) begin
            first_cyc = rx_cyc[0];
            for (int k = 0; k < 6; k++) begin
                chk($sformatf("%s_b%0d", tag, k), rx_q.pop_front(), e[k]);
                void'(rx_cyc.pop_front());
            end
        end
    endtask

    initial begin
        int fc, dc, prev_dc, en_seen, busy_lo;
        logic [11:0] va, ia, vb, ib, vc, ic;
        bus.sample_valid = 1'b0;
        bus.data_v       = '0;
        bus.data_i       = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tx_en", bus.tx_en, 0);
        chk("rst_tx_byte", bus.tx_byte, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_frame_done", bus.frame_done, 0);
        chk("rst_overrun", bus.overrun_cnt, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single frame with a slow UART, including first-byte latency
        uart_min = 10;
        uart_max = 10;
        @(negedge clk);
        bus.sample_valid = 1'b1;
        bus.data_v       = 12'hABC;
        bus.data_i       = 12'h123;
        @(posedge clk);
        #1 bus.sample_valid = 1'b0;
        chk("lat_busy", bus.busy, 1);
        chk("lat_c1_en", bus.tx_en, 0);
        @(posedge clk); #1;
        chk("lat_c2_en", bus.tx_en, 0);
        @(posedge clk); #1;
        chk("lat_c3_en", bus.tx_en, 1);
        chk("lat_c3_byte", bus.tx_byte, 8'hA5);
        expect_frame(12'hABC, 12'h123, "single", fc, dc);
        chk("single_overrun", bus.overrun_cnt, 0);
        chk("single_done_count", done_cnt, 1);

        // Sequence wrap over 17 frames of zero samples
        reset_dut();
        uart_min = 1;
        uart_max = 4;
        for (int f = 0; f < 17; f++) begin
            send_sample(12'h000, 12'h000);
            expect_frame(12'h000, 12'h000, $sformatf("wrap%0d", f), fc, dc);
        end

        // Random payloads and UART delays
        uart_max = 8;
        for (int f = 0; f < 8; f++) begin
            va = 12'($urandom);
            ia = 12'($urandom);
            send_sample(va, ia);
            expect_frame(va, ia, $sformatf("rand%0d", f), fc, dc);
        end

        // Pending path: second sample mid-frame runs straight after DONE
        reset_dut();
        uart_min = 2;
        uart_max = 2;
        va = 12'($urandom);
        ia = 12'($urandom);
        send_sample(va, ia);
        wait_bytes(1, "pend");
        send_sample(12'h555, 12'h0AA);
        expect_frame(va, ia, "pend1", fc, prev_dc);
        expect_frame(12'h555, 12'h0AA, "pend2", fc, dc);
        chk("pend_gap", fc - prev_dc, 4);
        chk("pend_overrun", bus.overrun_cnt, 0);

        // Overrun: two samples during one frame, the newest wins
        reset_dut();
        uart_min = 3;
        uart_max = 6;
        va = 12'($urandom);
        ia = 12'($urandom);
        vb = 12'($urandom);
        ib = 12'($urandom);
        vc = 12'h7FF;
        ic = 12'($urandom);
        send_sample(va, ia);
        wait_bytes(1, "ovr");
        send_sample(vb, ib);
        send_sample(vc, ic);
        ovr_m = (ovr_m + 1 > 255) ? 255 : ovr_m + 1;
        expect_frame(va, ia, "ovr1", fc, dc);
        expect_frame(vc, ic, "ovr2", fc, dc);
        chk("ovr_count", bus.overrun_cnt, ovr_m);

        // Handshake stall, 300 further overruns, then release
        repeat (15) @(posedge clk);
        uart_auto = 1'b0;
        @(negedge clk);
        bus.tx_ready = 1'b0;
        va = 12'($urandom);
        ia = 12'($urandom);
        send_sample(va, ia);
        en_seen = 0;
        busy_lo = 0;
        for (int c = 0; c < 50; c++) begin
            @(posedge clk); #1;
            if (bus.tx_en !== 1'b0) en_seen++;
            if (bus.busy !== 1'b1) busy_lo++;
        end
        chk("stall_no_tx_en", en_seen, 0);
        chk("stall_busy", busy_lo, 0);
        for (int k = 0; k < 301; k++) begin
            @(negedge clk);
            vb = 12'($urandom);
            ib = 12'($urandom);
            bus.sample_valid = 1'b1;
            bus.data_v       = vb;
            bus.data_i       = ib;
        end
        @(negedge clk);
        bus.sample_valid = 1'b0;
        ovr_m = (ovr_m + 300 > 255) ? 255 : ovr_m + 300;
        @(posedge clk); #1;
        chk("sat_overrun", bus.overrun_cnt, ovr_m);
        chk("sat_no_tx_en", bus.tx_en, 0);
        bus.tx_ready = 1'b1;
        uart_auto    = 1'b1;
        @(posedge clk); #1;
        chk("release_tx_en", bus.tx_en, 1);
        chk("release_byte", bus.tx_byte, 8'hA5);
        expect_frame(va, ia, "stall1", fc, dc);
        expect_frame(vb, ib, "stall2", fc, dc);
        chk("sat_overrun_hold", bus.overrun_cnt, 255);

        // Reset in the middle of B3
        repeat (15) @(posedge clk);
        uart_min = 10;
        uart_max = 10;
        va = 12'($urandom);
        ia = 12'($urandom);
        send_sample(va, ia);
        wait_bytes(4, "midrst");
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_tx_en", bus.tx_en, 0);
        chk("midrst_tx_byte", bus.tx_byte, 0);
        chk("midrst_busy", bus.busy, 0);
        chk("midrst_frame_done", bus.frame_done, 0);
        chk("midrst_overrun", bus.overrun_cnt, 0);
        rx_q.delete();
        rx_cyc.delete();
        seq_m = 0;
        ovr_m = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (15) @(posedge clk);
        va = 12'($urandom);
        ia = 12'($urandom);
        send_sample(va, ia);
        expect_frame(va, ia, "postrst", fc, dc);
        chk("postrst_overrun", bus.overrun_cnt, ovr_m);

        repeat (5) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/meter_packetizer.md
# meter_packetizer

Framing stage between the dual-channel meter and the UART transmitter. Captures each completed 12-bit voltage/current sample pair and serialises it as a fixed 6-byte frame: sync, sequence-tagged voltage, current, checksum. Drives the UART byte handshake (`tx_byte`/`tx_en`/`tx_ready`). Holds one pending sample and counts overruns, so meter cadence never stalls.

## Interface
- `SYNC_BYTE`, 8'hA5, first byte of every frame
- `clk` in 1: system clock (clk100 domain)
- `rst` in 1: asynchronous reset, active-low
- `sample_valid` in 1: one-cycle strobe, `data_v`/`data_i` valid
- `data_v` in 12: voltage sample
- `data_i` in 12: current sample
- `tx_ready` in 1: UART idle and can accept a byte
- `tx_byte` out 8: byte to UART, stable while `tx_en`=1
- `tx_en` out 1: one-cycle byte strobe to UART
- `busy` out 1: frame in progress (state != IDLE)
- `frame_done` out 1: one-cycle pulse after the last byte is accepted
- `overrun_cnt` out 8: saturating count of dropped samples

## Operation
- Frame bytes, in order:
  - B0 = SYNC_BYTE
  - B1 = {seq[3:0], V[11:8]}
  - B2 = V[7:0]
  - B3 = {4'h0, I[11:8]}
  - B4 = I[7:0]
  - B5 = (B1+B2+B3+B4) mod 256
- `seq` is a 4-bit counter. It increments on each `frame_done` and wraps F->0.
- States:
  - IDLE -> LOAD: on `sample_valid`, or when the pending flag is set.
  - LOAD: latch the frame registers, idx=0, compute checksum -> SEND.
  - SEND: wait for `tx_ready`=1. Then present B[idx] and pulse `tx_en` -> WAIT_ACK.
  - WAIT_ACK: wait for `tx_ready`=0. Then if idx=5 -> DONE, else idx+1 -> SEND.
  - DONE: pulse `frame_done`, seq+1 -> IDLE.
- Capture in IDLE:
  - If `sample_valid`=1, the fresh sample is used. If pending was also set, pending is discarded and `overrun_cnt`+1.
  - Otherwise, if pending is set, the pending sample is used and pending is cleared.
- Capture outside IDLE:
  - `sample_valid`=1 writes the pending registers.
  - If pending was already set, the old pending value is overwritten and `overrun_cnt`+1.
- `overrun_cnt` saturates at 255. It clears only on reset.
- `tx_byte` holds its last value between strobes.

## Timing
- Reset values: state IDLE, all other outputs 0 (`tx_en`, `tx_byte`, `busy`, `frame_done`, `overrun_cnt`), seq=0, pending flag=0.
- All outputs are registered.
- Latency, `sample_valid` to first `tx_en` with `tx_ready` held high: 3 cycles.
  - Edge 0: capture, state LOAD.
  - Edge 1: state SEND.
  - Edge 2: `tx_en`=1 visible in cycle 3.
- `tx_en` is never asserted while `tx_ready`=0, and is never high for 2 consecutive cycles.
- `tx_ready` must drop within a bounded time after `tx_en`. The block waits indefinitely in WAIT_ACK; there is no timeout.
- `frame_done` is high for exactly 1 cycle, 1 cycle after the `tx_ready` fall that follows B5.
- `busy` is high from the cycle after capture through the DONE cycle inclusive.
- Reset mid-frame: the block aborts immediately and `tx_en` drops asynchronously. The partial frame is not resumed; seq returns to 0.
- `sample_valid` in the DONE cycle is stored as pending. The next frame starts from IDLE one cycle later.

## Test plan
- Single frame:
  - Stimulus: reset, V=0xABC, I=0x123, UART model with `tx_ready` low for 10 cycles after each `tx_en`.
  - Required bytes: A5, 0A, BC, 01, 23, EA.
  - Required: one `frame_done` pulse; `overrun_cnt`=0.
- Sequence wrap:
  - Stimulus: 17 back-to-back frames, all with V=0x000.
  - Required: B1 upper nibble runs 0..F then 0; checksum equals B1.
- Pending path:
  - Stimulus: second sample (V=0x555, I=0x0AA) during frame 1.
  - Required: frame 2 starts with no idle gap beyond DONE->IDLE->LOAD; bytes A5, 15, 55, 00, AA, 14.
  - Required: `overrun_cnt`=0.
- Overrun:
  - Stimulus: 3 samples during one frame, the last being V=0x7FF.
  - Required: frame 2 carries V=0x7FF; `overrun_cnt`=1.
  - Stimulus: 300 overruns. Required: count saturates at 255.
- Handshake stall:
  - Stimulus: hold `tx_ready`=0 for 50 cycles after capture.
  - Required: no `tx_en`; `busy`=1.
  - Stimulus: release `tx_ready`. Required: B0 strobes 1 cycle later.
- Reset mid-frame:
  - Stimulus: assert `rst` low during B3.
  - Required: all outputs 0 immediately.
  - Stimulus: new sample after release. Required: frame with seq=0.
